collision_detector: RTL and testbench
=====================================

// Module: collision_detector
// PURPOSE
//  Frame-synchronous collision detector. Sits downstream of the sprite draw units, alongside Drawing_priority.
//  Samples the per-pixel draw flags (ship, torpedoes, rock field) during the raster scan.
//  Accumulates sticky per-frame hit flags.
//  At each vsync rising edge, reports one-cycle event pulses to lives_counter (die) and score_box (score_add).
//  Also owns the post-death invulnerability (grace) window.
// PARAMETERS
//  T_NUM         4   number of torpedo instances (matches the top-level torpedo count)
//  GRACE_FRAMES  120 frames of ship invulnerability after a death (~2 s at 60 Hz); 0 disables grace
// PORTS
//  clk           in   1                   pixel clock (clk_25)
//  reset         in   1                   synchronous, active-high reset
//  vsync         in   1                   raw v_sync from Screens_dispaly; edge detected internally
//  game_over     in   1                   level from lives_counter; suppresses all hits while high
//  draw_ship     in   1                   ship sprite drawing the current pixel
//  draw_torpedo  in   T_NUM               per-torpedo drawing flags
//  draw_rock     in   1                   any asteroid drawing the current pixel
//  die           out  1                   1-cycle pulse: ship collided during the last frame
//  torpedo_hit   out  T_NUM               1-cycle pulse per torpedo that hit a rock (drives torpedo kill)
//  score_add     out  1                   1-cycle pulse: at least one torpedo hit
//  hit_count     out  $clog2(T_NUM+1)     number of torpedo hits; valid while score_add is high, else 0
//  grace         out  1                   level: ship is currently invulnerable
// BEHAVIOUR
//  - Reset: all outputs 0; sticky flags cleared; grace counter = 0; vsync_d = 0.
//    Reset mid-frame discards any partial-frame hits.
//  - Edge: the edge cycle E is the cycle where vsync=1 and vsync_d=0. vsync_d is registered every cycle.
//  - Accumulate (every cycle, including E):
//    - ship_f  |= draw_ship & draw_rock & ~grace & ~game_over
//    - torp_f[t] |= draw_torpedo[t] & draw_rock & ~game_over
//  - Report: in cycle E+1, die = ship_f and torpedo_hit = torp_f, with the cycle-E samples OR'd in.
//    - score_add = |torpedo_hit; hit_count = popcount(torpedo_hit).
//    - Flags are cleared at E. Samples from E+1 onward belong to the next frame.
//    - All pulses are exactly 1 cycle wide. Latency from the edge is 1 cycle. Report at most once per frame.
//  - FSM: RUN (accumulate) -> REPORT on the edge cycle (1 cycle) -> RUN.
//    The grace sub-state is tracked by the counter, not by the FSM.
//  - Grace:
//    - die=1 loads the counter with GRACE_FRAMES in the same cycle.
//    - The counter decrements on each edge cycle while nonzero; it saturates at 0.
//    - grace = (counter != 0).
//    - Ship hits are evaluated per cycle, so pixels scanned after the counter reaches 0 count immediately.
//  - game_over=1: the grace counter is forced to 0 and flags stop accumulating.
//    A report already in flight (E+1) still completes.
//  - Simultaneous ship and torpedo hits in one frame: both reported in the same E+1 cycle.
//    One torpedo hitting several rocks counts once.
//  - Width rule: hit_count is zero-extended to $clog2(T_NUM+1) bits; no overflow (max T_NUM).
// CONFIGURATION
//  - COLLISION_COORD_EN defined:
//    - Adds inputs pxl_x[9:0] and pxl_y[8:0], and outputs hit_x[9:0] and hit_y[8:0].
//    - Latches the pixel of the FIRST ship collision of the frame.
//    - The coordinate is presented with die and held until the next die; reset value 0.
//  - Not defined: those ports and registers are absent; all other behaviour is identical.
// STRUCTURE
//  - asteroids_pkg: RGB_SRC enum, T_NUM, GRACE_FRAMES default, popcount function.
//    Shared with Drawing_priority and the top level.
//  - One sub-module: frame_edge (vsync register, rising-edge pulse).
//    Reused by the anim_pulse generator and the torpedo vsync input.
//  - Remainder is flat: flag registers, report stage, grace counter.
// TESTING
//  1. Ship+rock overlap on 5 pixels of line 200, then vsync rise at cycle E
//     -> die=1 only at E+1; grace=1 from E+1; grace stays high for exactly 120 edges.
//  2. Torpedoes 0 and 2 overlap rock in one frame
//     -> torpedo_hit=4'b0101, score_add=1, hit_count=2 at E+1; all 0 at E+2.
//  3. Ship overlaps rock while grace=1 (counter=3)
//     -> no die; overlap after the 3rd edge -> die at the next report.
//  4. game_over=1 with ship+torpedo overlaps -> no pulses; grace forced 0.
//  5. Hits accumulated, then reset for 1 cycle before the edge -> no pulses at E+1; all outputs 0.
//  6. COLLISION_COORD_EN: ship hits at (320,240), then (330,250) in the same frame
//     -> hit_x=320, hit_y=240 with die.

Source files
------------

// File: rtl/asteroids_pkg.sv
// Shared asteroids definitions: pixel-source enum, torpedo count, grace default, popcount.
package asteroids_pkg;

    typedef enum logic [1:0] {
        RGB_BG      = 2'd0,
        RGB_SHIP    = 2'd1,
        RGB_TORPEDO = 2'd2,
        RGB_ROCK    = 2'd3
    } rgb_src_e;

    localparam int T_NUM        = 4;
    localparam int GRACE_FRAMES = 120;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/collision_detector_frame_edge.sv
// Registers raw vsync and emits a one-cycle pulse in the cycle vsync first reads high.
module frame_edge (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    output logic rise
);

    logic vsync_q;
    logic vsync_d;

    always_comb begin
        vsync_d = vsync;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= vsync_d;
        end
    end

    assign rise = vsync & ~vsync_q;

endmodule

// File: rtl/collision_detector.sv
// Frame-synchronous collision detector with post-death grace window.
// Optional COLLISION_COORD_EN adds latching of the first ship-collision pixel of each frame.
module collision_detector #(
    parameter int T_NUM        = asteroids_pkg::T_NUM,
    parameter int GRACE_FRAMES = asteroids_pkg::GRACE_FRAMES
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       vsync,
    input  logic                       game_over,
    input  logic                       draw_ship,
    input  logic [T_NUM-1:0]           draw_torpedo,
    input  logic                       draw_rock,
`ifdef COLLISION_COORD_EN
    input  logic [9:0]                 pxl_x,
    input  logic [8:0]                 pxl_y,
    output logic [9:0]                 hit_x,
    output logic [8:0]                 hit_y,
`endif
    output logic                       die,
    output logic [T_NUM-1:0]           torpedo_hit,
    output logic                       score_add,
    output logic [$clog2(T_NUM+1)-1:0] hit_count,
    output logic                       grace
);

    import asteroids_pkg::*;

    localparam int HC_W  = $clog2(T_NUM + 1);
    localparam int CNT_W = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_REPORT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic               ship_f_q, ship_f_d;
    logic [T_NUM-1:0]   torp_f_q, torp_f_d;
    logic               ship_rep_q, ship_rep_d;
    logic [T_NUM-1:0]   torp_rep_q, torp_rep_d;
    logic [CNT_W-1:0]   grace_cnt_q, grace_cnt_d;
    logic               edge_pulse;
    logic               ship_sample;
    logic [T_NUM-1:0]   torp_sample;

    frame_edge u_frame_edge (
        .clk   (clk),
        .reset (reset),
        .vsync (vsync),
        .rise  (edge_pulse)
    );

    assign grace       = (grace_cnt_q != '0);
    assign ship_sample = draw_ship & draw_rock & ~grace & ~game_over;

    for (genvar gi = 0; gi < T_NUM; gi++) begin : g_torp
        assign torp_sample[gi] = draw_torpedo[gi] & draw_rock & ~game_over;
    end

    // The edge cycle's own samples still belong to the frame being closed.
    always_comb begin
        state_d     = ST_RUN;
        ship_f_d    = ship_f_q | ship_sample;
        torp_f_d    = torp_f_q | torp_sample;
        ship_rep_d  = ship_rep_q;
        torp_rep_d  = torp_rep_q;
        grace_cnt_d = grace_cnt_q;
        if (edge_pulse) begin
            state_d    = ST_REPORT;
            ship_rep_d = ship_f_q | ship_sample;
            torp_rep_d = torp_f_q | torp_sample;
            ship_f_d   = 1'b0;
            torp_f_d   = '0;
            if (grace_cnt_q != '0) begin
                grace_cnt_d = grace_cnt_q - CNT_W'(1);
            end
            if (ship_rep_d) begin
                grace_cnt_d = CNT_W'(GRACE_FRAMES);
            end
        end
        if (game_over) begin
            grace_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            ship_f_q    <= 1'b0;
            torp_f_q    <= '0;
            ship_rep_q  <= 1'b0;
            torp_rep_q  <= '0;
            grace_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ship_f_q    <= ship_f_d;
            torp_f_q    <= torp_f_d;
            ship_rep_q  <= ship_rep_d;
            torp_rep_q  <= torp_rep_d;
            grace_cnt_q <= grace_cnt_d;
        end
    end

    assign die         = (state_q == ST_REPORT) & ship_rep_q;
    assign torpedo_hit = (state_q == ST_REPORT) ? torp_rep_q : '0;
    assign score_add   = |torpedo_hit;
    assign hit_count   = HC_W'(popcount(32'(torpedo_hit)));

`ifdef COLLISION_COORD_EN
    logic [9:0] cap_x_q, cap_x_d, hit_x_q, hit_x_d;
    logic [8:0] cap_y_q, cap_y_d, hit_y_q, hit_y_d;

    // A hit on the edge cycle itself may be the frame's first, so use the live pixel then.
    always_comb begin
        cap_x_d = cap_x_q;
        cap_y_d = cap_y_q;
        hit_x_d = hit_x_q;
        hit_y_d = hit_y_q;
        if (ship_sample && !ship_f_q) begin
            cap_x_d = pxl_x;
            cap_y_d = pxl_y;
        end
        if (edge_pulse && ship_rep_d) begin
            hit_x_d = ship_f_q ? cap_x_q : pxl_x;
            hit_y_d = ship_f_q ? cap_y_q : pxl_y;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_x_q <= '0;
            cap_y_q <= '0;
            hit_x_q <= '0;
            hit_y_q <= '0;
        end else begin
            cap_x_q <= cap_x_d;
            cap_y_q <= cap_y_d;
            hit_x_q <= hit_x_d;
            hit_y_q <= hit_y_d;
        end
    end

    assign hit_x = hit_x_q;
    assign hit_y = hit_y_q;
`endif

endmodule

// File: tb/tb_collision_detector.sv
// Self-checking bench for collision_detector; COLLISION_COORD_EN enables the coordinate test.
module tb_collision_detector;

    localparam int GRACE = 120;

    logic       clk;
    logic       reset;
    logic       vsync;
    logic       game_over;
    logic       draw_ship;
    logic [3:0] draw_torpedo;
    logic       draw_rock;
    logic       die;
    logic [3:0] torpedo_hit;
    logic       score_add;
    logic [2:0] hit_count;
    logic       grace;
`ifdef COLLISION_COORD_EN
    logic [9:0] pxl_x;
    logic [8:0] pxl_y;
    logic [9:0] hit_x;
    logic [8:0] hit_y;
`endif

    int tests_run;
    int tests_failed;

    // Reference model state: frame-level hit sets and remaining grace frames.
    logic       m_ship;
    logic [3:0] m_torp;
    int         m_grace;
    logic       m_prev_vs;
    logic       e_die;
    logic [3:0] e_torp;
    logic [9:0] exp_v;
    logic [9:0] obs;

    assign obs = {die, torpedo_hit, score_add, hit_count, grace};

    collision_detector #(
        .T_NUM        (4),
        .GRACE_FRAMES (GRACE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .vsync        (vsync),
        .game_over    (game_over),
        .draw_ship    (draw_ship),
        .draw_torpedo (draw_torpedo),
        .draw_rock    (draw_rock),
`ifdef COLLISION_COORD_EN
        .pxl_x        (pxl_x),
        .pxl_y        (pxl_y),
        .hit_x        (hit_x),
        .hit_y        (hit_y),
`endif
        .die          (die),
        .torpedo_hit  (torpedo_hit),
        .score_add    (score_add),
        .hit_count    (hit_count),
        .grace        (grace)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus; afterwards exp_v holds what the outputs must show.
    task automatic step(input logic i_vs, input logic i_ship, input logic i_rock,
                        input logic [3:0] i_torp, input logic i_go, input logic i_rst);
        logic       hit_s;
        logic [3:0] hit_t;
        vsync        = i_vs;
        draw_ship    = i_ship;
        draw_rock    = i_rock;
        draw_torpedo = i_torp;
        game_over    = i_go;
        reset        = i_rst;
        @(posedge clk);
        if (i_rst) begin
            m_ship    = 1'b0;
            m_torp    = 4'b0;
            m_grace   = 0;
            m_prev_vs = 1'b0;
            e_die     = 1'b0;
            e_torp    = 4'b0;
        end else begin
            hit_s = i_ship && i_rock && (m_grace == 0) && !i_go;
            hit_t = (i_rock && !i_go) ? i_torp : 4'b0;
            if (i_vs && !m_prev_vs) begin
                e_die  = m_ship | hit_s;
                e_torp = m_torp | hit_t;
                m_ship = 1'b0;
                m_torp = 4'b0;
                if (i_go)            m_grace = 0;
                else if (e_die)      m_grace = GRACE;
                else if (m_grace > 0) m_grace = m_grace - 1;
            end else begin
                e_die  = 1'b0;
                e_torp = 4'b0;
                m_ship = m_ship | hit_s;
                m_torp = m_torp | hit_t;
                if (i_go) m_grace = 0;
            end
            m_prev_vs = i_vs;
        end
        exp_v = {e_die, e_torp, (e_torp != 4'b0), 3'($countones(e_torp)), (m_grace != 0)};
        #1;
    endtask

    // Low phase with rock overlap on cycles h_lo..h_hi, then one edge cycle.
    task automatic drive_frame(input int n_low, input int h_lo, input int h_hi,
                               input logic ship, input logic [3:0] tmask, input logic go);
        for (int c = 0; c < n_low; c++) begin
            step(1'b0, ship, (c >= h_lo && c <= h_hi), tmask, go, 1'b0);
        end
        step(1'b1, 1'b0, 1'b0, 4'b0, go, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b1);
        tests_run++;
        if (obs !== 10'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected %b", obs, 10'b0);
        end
    endtask

    task automatic test_ship_die();
        int grace_edges;
        step(1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            step(1'b0, (c >= 3 && c <= 7), (c >= 3 && c <= 7), 4'b0, 1'b0, 1'b0);
            tests_run++;
            if (die !== 1'b0 || grace !== 1'b0) begin
                tests_failed++;
                $display("FAIL ship_early: cycle %0d die=%b grace=%b expected 0 0", c, die, grace);
            end
        end
        step(1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
        tests_run++;
        if (die !== 1'b1 || grace !== 1'b1) begin
            tests_failed++;
            $display("FAIL ship_die_e1: die=%b grace=%b expected 1 1", die, grace);
        end
        step(1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
        tests_run++;
        if (die !== 1'b0 || grace !== 1'b1) begin
            tests_failed++;
            $display("FAIL ship_die_e2: die=%b grace=%b expected 0 1", die, grace);
        end
        grace_edges = 0;
        for (int f = 0; f < 125; f++) begin
            if (grace === 1'b1) grace_edges++;
            drive_frame(2, 1, 0, 1'b0, 4'b0, 1'b0);
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL grace_frame: frame %0d got %b expected %b", f, obs, exp_v);
            end
        end
        tests_run++;
        if (grace_edges !== GRACE) begin
            tests_failed++;
            $display("FAIL grace_length: got %0d edges expected %0d", grace_edges, GRACE);
        end
    endtask

    task automatic test_torpedo_hits();
        step(1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
        tests_run++;
        if (torpedo_hit !== 4'b0101 || score_add !== 1'b1 || hit_count !== 3'd2 || die !== 1'b0) begin
            tests_failed++;
            $display("FAIL torp_report: hit=%b score=%b cnt=%0d die=%b expected 0101 1 2 0",
                     torpedo_hit, score_add, hit_count, die);
        end
        step(1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
        tests_run++;
        if (obs !== 10'b0) begin
            tests_failed++;
            $display("FAIL torp_clear: got %b expected %b", obs, 10'b0);
        end
    endtask

    task automatic test_grace_window();
        step(1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b1);
        drive_frame(4, 1, 2, 1'b1, 4'b0, 1'b0);
        for (int f = 0; f < GRACE - 3; f++) begin
            drive_frame(2, 1, 0, 1'b0, 4'b0, 1'b0);
        end
        tests_run++;
        if (grace !== 1'b1) begin
            tests_failed++;
            $display("FAIL grace_at3: grace=%b expected 1", grace);
        end
        for (int f = 0; f < 3; f++) begin
            drive_frame(6, 1, 3, 1'b1, 4'b0, 1'b0);
            tests_run++;
            if (die !== 1'b0 || obs !== exp_v) begin
                tests_failed++;
                $display("FAIL grace_blocks: frame %0d got %b expected %b", f, obs, exp_v);
            end
        end
        tests_run++;
        if (grace !== 1'b0) begin
            tests_failed++;
            $display("FAIL grace_expired: grace=%b expected 0", grace);
        end
        drive_frame(6, 1, 3, 1'b1, 4'b0, 1'b0);
        tests_run++;
        if (die !== 1'b1 || grace !== 1'b1) begin
            tests_failed++;
            $display("FAIL grace_then_die: die=%b grace=%b expected 1 1", die, grace);
        end
    endtask

    task automatic test_game_over();
        step(1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b1);
        drive_frame(4, 1, 2, 1'b1, 4'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 4'b0, 1'b1, 1'b0);
        tests_run++;
        if (grace !== 1'b0) begin
            tests_failed++;
            $display("FAIL go_grace: grace=%b expected 0", grace);
        end
        drive_frame(6, 0, 5, 1'b1, 4'b1111, 1'b1);
        tests_run++;
        if (obs !== 10'b0) begin
            tests_failed++;
            $display("FAIL go_suppress: got %b expected %b", obs, 10'b0);
        end
        drive_frame(4, 1, 1, 1'b0, 4'b1000, 1'b0);
        tests_run++;
        if (obs !== exp_v || torpedo_hit !== 4'b1000) begin
            tests_failed++;
            $display("FAIL go_release: got %b expected %b", obs, exp_v);
        end
    endtask

    task automatic test_reset_mid_frame();
        step(1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
        tests_run++;
        if (obs !== 10'b0) begin
            tests_failed++;
            $display("FAIL reset_discard: got %b expected %b", obs, 10'b0);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0);
        tests_run++;
        if (torpedo_hit !== 4'b0010 || hit_count !== 3'd1) begin
            tests_failed++;
            $display("FAIL b2b_edge_sample: hit=%b cnt=%0d expected 0010 1", torpedo_hit, hit_count);
        end
        step(1'b1, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b0);
        tests_run++;
        if (torpedo_hit !== 4'b0000 || score_add !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_single_pulse: hit=%b score=%b expected 0000 0", torpedo_hit, score_add);
        end
        step(1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
        tests_run++;
        if (torpedo_hit !== 4'b1001 || die !== 1'b1 || hit_count !== 3'd2) begin
            tests_failed++;
            $display("FAIL b2b_next_frame: hit=%b die=%b cnt=%0d expected 1001 1 2",
                     torpedo_hit, die, hit_count);
        end
    endtask

    task automatic test_random();
        logic go;
        int   n_low;
        int   n_high;
        step(1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b1);
        for (int f = 0; f < 60; f++) begin
            go     = ($urandom_range(0, 9) == 0);
            n_low  = $urandom_range(3, 12);
            n_high = $urandom_range(1, 3);
            for (int c = 0; c < n_low + n_high; c++) begin
                step((c >= n_low), ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
                     4'($urandom_range(0, 15)), go, 1'b0);
                tests_run++;
                if (obs !== exp_v) begin
                    tests_failed++;
                    $display("FAIL random: frame %0d cycle %0d got %b expected %b", f, c, obs, exp_v);
                end
            end
        end
    endtask

`ifdef COLLISION_COORD_EN
    task automatic test_coord();
        step(1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b1);
        tests_run++;
        if (hit_x !== 10'd0 || hit_y !== 9'd0) begin
            tests_failed++;
            $display("FAIL coord_reset: got (%0d,%0d) expected (0,0)", hit_x, hit_y);
        end
        pxl_x = 10'd320; pxl_y = 9'd240;
        step(1'b0, 1'b1, 1'b1, 4'b0, 1'b0, 1'b0);
        pxl_x = 10'd325; pxl_y = 9'd245;
        step(1'b0, 1'b0, 1'b1, 4'b0, 1'b0, 1'b0);
        pxl_x = 10'd330; pxl_y = 9'd250;
        step(1'b0, 1'b1, 1'b1, 4'b0, 1'b0, 1'b0);
        pxl_x = 10'd0; pxl_y = 9'd0;
        step(1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
        tests_run++;
        if (die !== 1'b1 || hit_x !== 10'd320 || hit_y !== 9'd240) begin
            tests_failed++;
            $display("FAIL coord_first: die=%b got (%0d,%0d) expected 1 (320,240)", die, hit_x, hit_y);
        end
        step(1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
        tests_run++;
        if (hit_x !== 10'd320 || hit_y !== 9'd240) begin
            tests_failed++;
            $display("FAIL coord_hold: got (%0d,%0d) expected (320,240)", hit_x, hit_y);
        end
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        vsync        = 1'b0;
        game_over    = 1'b0;
        draw_ship    = 1'b0;
        draw_torpedo = 4'b0;
        draw_rock    = 1'b0;
        reset        = 1'b1;
        m_ship       = 1'b0;
        m_torp       = 4'b0;
        m_grace      = 0;
        m_prev_vs    = 1'b0;
        e_die        = 1'b0;
        e_torp       = 4'b0;
        exp_v        = 10'b0;
`ifdef COLLISION_COORD_EN
        pxl_x        = 10'd0;
        pxl_y        = 9'd0;
`endif
        test_reset();
        test_ship_die();
        test_torpedo_hits();
        test_grace_window();
        test_game_over();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
`ifdef COLLISION_COORD_EN
        test_coord();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
